// File: rtl/burst_memory_responder.sv
// Main-memory responder below the cache. It services line-fill read bursts and
// write-back bursts over a write/read/oe strobe bus with a shared 8-bit data bus.
module burst_memory_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic        oe,
  input  logic [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [7:0]  state,
  output logic [3:0]  count
);

  localparam int unsigned WAIT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int unsigned DEPTH  = 1 << ADDR_BITS;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    RD_WAIT  = 5'b00010,
    RD_BURST = 5'b00100,
    WR_BURST = 5'b01000,
    DONE     = 5'b10000
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           rdata_q, rdata_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [ADDR_BITS-1:0] line_base;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           mem_q [DEPTH];
  logic                 unused_addr_hi;

  assign line_base      = address_bus[ADDR_BITS-1:0] & ~ADDR_BITS'(BURST_LEN - 1);
  assign unused_addr_hi = ^address_bus[15:ADDR_BITS];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    base_d    = base_q;
    wait_d    = wait_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = base_q + ADDR_BITS'(count_q);

    unique case (state_q)
      IDLE: begin
        if (read && write) begin
          err_d = 1'b1;
        end else if (read) begin
          base_d  = line_base;
          count_d = '0;
          wait_d  = WAIT_W'(LATENCY);
          if (LATENCY == 0) state_d = RD_BURST;
          else              state_d = RD_WAIT;
        end else if (write) begin
          // first write beat lands on the same edge that accepts the request
          base_d    = line_base;
          mem_we    = 1'b1;
          mem_waddr = line_base;
          count_d   = 4'd1;
          if (BURST_LEN == 1) state_d = DONE;
          else                state_d = WR_BURST;
        end
      end
      RD_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WAIT_W'(1)) state_d = RD_BURST;
      end
      RD_BURST: begin
        if (oe) begin
          count_d = count_q + 4'd1;
          if (count_q == 4'(BURST_LEN - 1)) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (write) begin
          mem_we  = 1'b1;
          count_d = count_q + 4'd1;
          if (count_q == 4'(BURST_LEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!read && !write) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    rd_addr = base_d + ADDR_BITS'(count_d);
    rdata_d = rdata_q;
    if (state_d == RD_BURST) rdata_d = mem_q[rd_addr];

    ready_d = (state_d == RD_BURST) || (state_d == WR_BURST);
    done_d  = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      base_q  <= '0;
      wait_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage survives reset; writes are simply blocked while reset is held.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= data_bus;
  end

  assign data_bus = (state_q == RD_BURST && oe) ? rdata_q : 'z;

  assign state = {3'b000, state_q};
  assign count = count_q;
  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;

  a_count_range: assert property (@(posedge clock) disable iff (reset)
    count_q <= 4'(BURST_LEN));
  a_state_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot(state_q));

endmodule

// File: tb/tb_burst_memory_responder.sv
// Randomized bench for burst_memory_responder: a transaction-level model predicts
// every cycle's outputs, with directed cases pinned by hand-computed literals.
module tb_burst_memory_responder;

  localparam int AB  = 8;
  localparam int BL  = 4;
  localparam int LAT = 3;

  localparam logic [7:0] S_IDLE = 8'h01;
  localparam logic [7:0] S_WAIT = 8'h02;
  localparam logic [7:0] S_RD   = 8'h04;
  localparam logic [7:0] S_WR   = 8'h08;
  localparam logic [7:0] S_DONE = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr = 1'b0, rd = 1'b0, oe = 1'b0;
  logic [15:0] addr = '0;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_data = '0;
  wire  [7:0]  data_bus;
  assign data_bus = drv_en ? drv_data : 8'hzz;
  logic        ready, done, err;
  logic [7:0]  state;
  logic [3:0]  count;

  burst_memory_responder #(.ADDR_BITS(AB), .BURST_LEN(BL), .LATENCY(LAT)) dut (
    .clock(clk), .reset(rst), .write(wr), .read(rd), .oe(oe),
    .address_bus(addr), .data_bus(data_bus), .ready(ready), .done(done),
    .err(err), .state(state), .count(count)
  );

  logic        wr1 = 1'b0, rd1 = 1'b0, oe1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic        drv1_en = 1'b0;
  logic [7:0]  drv1_data = '0;
  wire  [7:0]  bus1;
  assign bus1 = drv1_en ? drv1_data : 8'hzz;
  logic        ready1, done1, err1;
  logic [7:0]  state1;
  logic [3:0]  count1;

  burst_memory_responder #(.ADDR_BITS(8), .BURST_LEN(1), .LATENCY(0)) dut1 (
    .clock(clk), .reset(rst), .write(wr1), .read(rd1), .oe(oe1),
    .address_bus(addr1), .data_bus(bus1), .ready(ready1), .done(done1),
    .err(err1), .state(state1), .count(count1)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mem_m [256];
  int         cur_base = 0;
  logic       chk_en = 1'b0;
  logic [7:0] exp_state = S_IDLE;
  logic [3:0] exp_count = '0;
  logic       exp_ready = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [7:0] exp_data = '0;

  int         cyc_ctr = 0, rdy_seen = 0, done_seen = 0;
  logic [3:0] stall_cnt = '0;
  logic [7:0] held_state = '0;
  logic [31:0] seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("state", state, exp_state);
      chk("count", count, exp_count);
      chk("ready", ready, exp_ready);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      if (exp_state == S_RD && oe) chk("rdata", data_bus, exp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_ctr++;
    if (ready && rdy_seen == 0) rdy_seen = cyc_ctr;
    if (done) done_seen++;
  endtask

  task automatic set_exp(input logic [7:0] st, input int c, input logic r,
                         input logic d, input logic e);
    exp_state = st;
    exp_count = 4'(c);
    exp_ready = r;
    exp_done  = d;
    exp_err   = e;
    if (st == S_RD) exp_data = mem_m[(cur_base + c) & 255];
  endtask

  task automatic start_txn();
    cyc_ctr = 0;
    rdy_seen = 0;
    done_seen = 0;
  endtask

  // Holds the request lines for `hold` cycles in DONE, then releases them.
  task automatic finish_done(input int hold, input bit rd_only);
    for (int h = 0; h < hold; h++) begin
      int m = rd_only ? 0 : int'($urandom_range(2, 0));
      rd = (m != 1);
      wr = (m != 0);
      tick();
      set_exp(S_DONE, BL, 1'b0, 1'b0, 1'b0);
      held_state = state;
    end
    rd = 1'b0;
    wr = 1'b0;
    tick();
    set_exp(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] dw,
                          input int stall_pct, input int hold);
    int b = int'(a[7:0]) & 8'hFC;
    start_txn();
    cur_base = b;
    oe = 1'b0; rd = 1'b0; wr = 1'b1; addr = a;
    drv_en = 1'b1; drv_data = dw[7:0];
    tick();
    mem_m[b] = dw[7:0];
    set_exp(S_WR, 1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < BL; k++) begin
      int ns = 0;
      while (ns < 3 && int'($urandom_range(99, 0)) < stall_pct) begin
        wr = 1'b0; rd = 1'($urandom_range(1, 0)); drv_data = 8'($urandom);
        tick();
        set_exp(S_WR, k, 1'b1, 1'b0, 1'b0);
        ns++;
      end
      wr = 1'b1;
      rd = (stall_pct > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      drv_data = dw[8*k +: 8];
      tick();
      mem_m[b + k] = dw[8*k +: 8];
      if (k == BL - 1) set_exp(S_DONE, BL, 1'b0, 1'b1, 1'b0);
      else             set_exp(S_WR, k + 1, 1'b1, 1'b0, 1'b0);
    end
    drv_en = 1'b0;
    finish_done(hold, 1'b0);
  endtask

  task automatic do_read(input logic [15:0] a, input int stall_pct, input int fbeat,
                         input int flen, input int hold, input bit rd_only,
                         output logic [31:0] got);
    int b = int'(a[7:0]) & 8'hFC;
    start_txn();
    cur_base = b;
    got = '0;
    rd = 1'b1; wr = 1'b0; addr = a; drv_en = 1'b0;
    oe = (stall_pct > 0) ? 1'($urandom_range(1, 0)) : 1'b1;
    tick();
    set_exp((LAT == 0) ? S_RD : S_WAIT, 0, (LAT == 0), 1'b0, 1'b0);
    rd = rd_only;
    for (int j = 1; j <= LAT; j++) begin
      if (stall_pct > 0) oe = 1'($urandom_range(1, 0));
      tick();
      if (j == LAT) set_exp(S_RD, 0, 1'b1, 1'b0, 1'b0);
      else          set_exp(S_WAIT, 0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < BL; k++) begin
      int ns = (k == fbeat) ? flen : 0;
      for (int s = 0; s < ns; s++) begin
        oe = 1'b0;
        tick();
        set_exp(S_RD, k, 1'b1, 1'b0, 1'b0);
        stall_cnt = count;
      end
      ns = 0;
      while (ns < 3 && int'($urandom_range(99, 0)) < stall_pct) begin
        oe = 1'b0;
        tick();
        set_exp(S_RD, k, 1'b1, 1'b0, 1'b0);
        ns++;
      end
      oe = 1'b1;
      @(negedge clk);
      got[8*k +: 8] = data_bus;
      tick();
      if (k == BL - 1) set_exp(S_DONE, BL, 1'b0, 1'b1, 1'b0);
      else             set_exp(S_RD, k + 1, 1'b1, 1'b0, 1'b0);
    end
    oe = 1'b0;
    finish_done(hold, rd_only);
  endtask

  task automatic do_err(input logic [15:0] a);
    rd = 1'b1; wr = 1'b1; addr = a; drv_en = 1'b0;
    tick();
    set_exp(S_IDLE, 0, 1'b0, 1'b0, 1'b1);
    chk("err_pulse", err, 1'b1);
    chk("err_state", state, S_IDLE);
    rd = 1'b0; wr = 1'b0;
    tick();
    set_exp(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, S_IDLE);
    chk("rst_count", count, 4'd0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    set_exp(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    tick();

    // write line 0x10 then read it back with oe held
    do_write(16'h0011, 32'h332211FF, 0, 0);
    chk("wr_done_once", done_seen, 1);
    do_read(16'h0013, 0, -1, 0, 0, 1'b0, seen);
    chk("rd_data", seen, 32'h332211FF);
    chk("rd_ready_cycle", rdy_seen, 4);
    chk("rd_done_once", done_seen, 1);

    // three-cycle oe stall before beat 1
    do_read(16'h0013, 0, 1, 3, 0, 1'b0, seen);
    chk("stall_data", seen, 32'h332211FF);
    chk("stall_count", stall_cnt, 4'd1);
    chk("stall_done_once", done_seen, 1);

    // read request held through DONE
    do_read(16'h0011, 0, -1, 0, 5, 1'b1, seen);
    chk("held_state", held_state, S_DONE);
    chk("held_done_once", done_seen, 1);

    // protocol error leaves storage untouched
    do_err(16'h0010);
    do_read(16'h0012, 0, -1, 0, 0, 1'b0, seen);
    chk("err_no_change", seen, 32'h332211FF);

    // reset during RD_WAIT
    rd = 1'b1; addr = 16'h0013; cur_base = 16;
    tick(); set_exp(S_WAIT, 0, 1'b0, 1'b0, 1'b0);
    rd = 1'b0;
    tick(); set_exp(S_WAIT, 0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_state", state, S_IDLE);
    chk("rstw_ready", ready, 1'b0);
    chk("rstw_count", count, 4'd0);
    set_exp(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // reset while beat 2 (0xAA) is being presented
    wr = 1'b1; addr = 16'h0010; drv_en = 1'b1; drv_data = 8'h55;
    tick(); mem_m[16] = 8'h55; set_exp(S_WR, 1, 1'b1, 1'b0, 1'b0);
    drv_data = 8'h66;
    tick(); mem_m[17] = 8'h66; set_exp(S_WR, 2, 1'b1, 1'b0, 1'b0);
    drv_data = 8'hAA;
    #2 rst = 1'b1; wr = 1'b0; drv_en = 1'b0;
    #1;
    chk("rstb_state", state, S_IDLE);
    chk("rstb_ready", ready, 1'b0);
    chk("rstb_count", count, 4'd0);
    set_exp(S_IDLE, 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    do_read(16'h0012, 0, -1, 0, 0, 1'b0, seen);
    chk("abort_write", seen, 32'h33226655);

    // LATENCY=0, BURST_LEN=1 instance, with address aliasing above ADDR_BITS
    wr1 = 1'b1; addr1 = 16'h01FE; drv1_en = 1'b1; drv1_data = 8'h5A;
    tick();
    chk("b1_wr_state", state1, S_DONE);
    chk("b1_wr_count", count1, 4'd1);
    chk("b1_wr_done", done1, 1'b1);
    chk("b1_wr_ready", ready1, 1'b0);
    wr1 = 1'b0; drv1_en = 1'b0;
    tick();
    chk("b1_idle", state1, S_IDLE);
    rd1 = 1'b1; oe1 = 1'b1; addr1 = 16'h00FE;
    tick();
    chk("b1_rd_state", state1, S_RD);
    chk("b1_rd_ready", ready1, 1'b1);
    chk("b1_rd_count", count1, 4'd0);
    rd1 = 1'b0;
    @(negedge clk);
    chk("b1_rd_data", bus1, 8'h5A);
    tick();
    chk("b1_rd_done_state", state1, S_DONE);
    chk("b1_rd_done", done1, 1'b1);
    chk("b1_rd_count1", count1, 4'd1);
    oe1 = 1'b0;
    tick();
    chk("b1_back_idle", state1, S_IDLE);
    chk("b1_no_err", err1, 1'b0);

    // preload every line, then random traffic
    for (int l = 0; l < 64; l++) begin
      logic [15:0] a = {8'($urandom), 8'(l * 4 + int'($urandom_range(3, 0)))};
      do_write(a, $urandom, 20, int'($urandom_range(2, 0)));
    end
    for (int t = 0; t < 60; t++) begin
      int r = int'($urandom_range(9, 0));
      logic [15:0] a = 16'($urandom);
      if (r < 4)      do_write(a, $urandom, 30, int'($urandom_range(2, 0)));
      else if (r < 9) do_read(a, 30, -1, 0, int'($urandom_range(2, 0)), 1'b0, seen);
      else            do_err(a);
      repeat (int'($urandom_range(2, 0))) tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
